// File: rtl/queue_fifo_pkg.sv
// Shared constants for the queue FIFO: default geometry and pointer width.
package queue_fifo_pkg;

  localparam int unsigned DefaultDataWidth = 8;
  localparam int unsigned DefaultAddrBits  = 4;

  // Pointers carry one extra wrap bit above the storage address.
  localparam int unsigned DefaultPtrWidth  = DefaultAddrBits + 1;

  typedef logic [DefaultPtrWidth-1:0] defaultPtrT;

endpackage : queue_fifo_pkg

// File: rtl/queue_fifo_ptr_compare.sv
// Equality check between two pointer (or pointer-slice) values.
module ptr_compare #(
  parameter int unsigned Width = 5
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic             equal_o
);

  // Pure combinational compare, used both for full pointers and address slices.
  always_comb begin
    equal_o = (a_i == b_i);
  end

endmodule : ptr_compare

// File: rtl/queue_fifo.sv
// Synchronous FIFO queue with wrap-bit pointers, registered read data and
// one-cycle overflow/underflow pulses.
module queue_fifo
  import queue_fifo_pkg::*;
#(
  parameter int unsigned DataWidth = DefaultDataWidth,
  parameter int unsigned AddrBits  = DefaultAddrBits
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 WriteEn,
  input  logic [DataWidth-1:0] DataIn,
  input  logic                 ReadEn,
  output logic [DataWidth-1:0] DataOut,
  output logic                 DataValid,
  output logic                 Full,
  output logic                 Empty,
  output logic [AddrBits:0]    Count,
  output logic                 Overflow,
  output logic                 Underflow
);

  localparam int unsigned PtrWidth = AddrBits + 1;
  localparam int unsigned Depth    = 1 << AddrBits;

  logic [DataWidth-1:0] mem_q [Depth];

  logic [PtrWidth-1:0]  wrPtr_q, wrPtr_d;
  logic [PtrWidth-1:0]  rdPtr_q, rdPtr_d;
  logic [DataWidth-1:0] dataOut_q, dataOut_d;
  logic                 dataValid_q, dataValid_d;
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;

  logic                 ptrEqual;
  logic                 addrEqual;
  logic                 wrAccept;
  logic                 rdAccept;

  logic [AddrBits-1:0]  wrAddr;
  logic [AddrBits-1:0]  rdAddr;

  assign wrAddr = wrPtr_q[AddrBits-1:0];
  assign rdAddr = rdPtr_q[AddrBits-1:0];

  ptr_compare #(
    .Width (PtrWidth)
  ) u_emptyCompare (
    .a_i     (wrPtr_q),
    .b_i     (rdPtr_q),
    .equal_o (ptrEqual)
  );

  ptr_compare #(
    .Width (AddrBits)
  ) u_addrCompare (
    .a_i     (wrAddr),
    .b_i     (rdAddr),
    .equal_o (addrEqual)
  );

  // Status flags decode straight from the registered pointers.
  always_comb begin
    Empty = ptrEqual;
    Full  = addrEqual && (wrPtr_q[AddrBits] != rdPtr_q[AddrBits]);
    Count = wrPtr_q - rdPtr_q;
  end

  // Acceptance rules: a full queue still takes a write when a read frees a slot.
  always_comb begin
    wrAccept = WriteEn && (!Full || ReadEn);
    rdAccept = ReadEn && !Empty;
  end

  // Next-state for pointers, read data and the pulse flags.
  always_comb begin
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    dataOut_d   = dataOut_q;
    dataValid_d = 1'b0;
    overflow_d  = WriteEn && Full && !ReadEn;
    underflow_d = ReadEn && Empty;
    if (wrAccept) begin
      wrPtr_d = wrPtr_q + 1'b1;
    end
    if (rdAccept) begin
      rdPtr_d     = rdPtr_q + 1'b1;
      dataOut_d   = mem_q[rdAddr];
      dataValid_d = 1'b1;
    end
  end

  // Control and output registers; reset empties the queue asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      dataOut_q   <= '0;
      dataValid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      dataOut_q   <= dataOut_d;
      dataValid_q <= dataValid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wrAccept) begin
      mem_q[wrAddr] <= DataIn;
    end
  end

  assign DataOut   = dataOut_q;
  assign DataValid = dataValid_q;
  assign Overflow  = overflow_q;
  assign Underflow = underflow_q;

endmodule : queue_fifo

// File: tb/tb_queue_fifo.sv
// Self-checking bench for queue_fifo: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_queue_fifo;

  localparam int Depth = 16;

  logic       clk;
  logic       rst_n;
  logic       writeEn;
  logic [7:0] dataIn;
  logic       readEn;
  logic [7:0] dataOut;
  logic       dataValid;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  int checks;
  int failures;

  logic [7:0] model[$];
  logic [7:0] expOut;
  logic       expValid;
  logic       expOverflow;
  logic       expUnderflow;

  queue_fifo #(
    .DataWidth (8),
    .AddrBits  (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .WriteEn   (writeEn),
    .DataIn    (dataIn),
    .ReadEn    (readEn),
    .DataOut   (dataOut),
    .DataValid (dataValid),
    .Full      (full),
    .Empty     (empty),
    .Count     (count),
    .Overflow  (overflow),
    .Underflow (underflow)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t",
               tag, observed, expected, $time);
    end
  endtask

  // Compare every visible output against the reference model.
  task automatic compareAll(input string ctx);
    checkOutput({ctx, ":Count"},     32'(count),     32'(model.size()));
    checkOutput({ctx, ":Empty"},     32'(empty),     32'(model.size() == 0));
    checkOutput({ctx, ":Full"},      32'(full),      32'(model.size() == Depth));
    checkOutput({ctx, ":DataValid"}, 32'(dataValid), 32'(expValid));
    checkOutput({ctx, ":DataOut"},   32'(dataOut),   32'(expOut));
    checkOutput({ctx, ":Overflow"},  32'(overflow),  32'(expOverflow));
    checkOutput({ctx, ":Underflow"}, 32'(underflow), 32'(expUnderflow));
  endtask

  // Drive one cycle of requests, advance the model at the edge, then check.
  task automatic applyStimulus(input logic we, input logic [7:0] din,
                               input logic re, input string ctx);
    bit isFull;
    bit isEmpty;
    writeEn = we;
    dataIn  = din;
    readEn  = re;
    @(posedge clk);
    isFull       = (model.size() == Depth);
    isEmpty      = (model.size() == 0);
    expOverflow  = we && isFull && !re;
    expUnderflow = re && isEmpty;
    expValid     = 1'b0;
    if (re && !isEmpty) begin
      expOut   = model.pop_front();
      expValid = 1'b1;
    end
    if (we && (!isFull || re)) model.push_back(din);
    #1;
    compareAll(ctx);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    expOut = 8'h00; expValid = 1'b0; expOverflow = 1'b0; expUnderflow = 1'b0;
    writeEn = 1'b0; readEn = 1'b0; dataIn = 8'h00;
    rst_n = 1'b0;
    #12;
    compareAll("reset");
    rst_n = 1'b1;

    // Fill with 0x01..0x10
    for (int i = 1; i <= Depth; i++) applyStimulus(1'b1, 8'(i), 1'b0, "fill");
    checkOutput("fillFull", 32'(full), 32'd1);

    // Write into a full queue without reading
    applyStimulus(1'b1, 8'hEE, 1'b0, "overflow");
    applyStimulus(1'b0, 8'h00, 1'b0, "overflowDone");

    // Drain in order
    for (int i = 1; i <= Depth; i++) applyStimulus(1'b0, 8'h00, 1'b1, "drain");
    applyStimulus(1'b0, 8'h00, 1'b0, "drainIdle");

    // Pointer wrap: 10 in, 10 out, twice
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'(8'h30 + r*16 + i), 1'b0, "wrapWrite");
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 8'h00, 1'b1, "wrapRead");
    end
    applyStimulus(1'b0, 8'h00, 1'b0, "wrapIdle");

    // Simultaneous read/write on an empty queue: no bypass
    applyStimulus(1'b1, 8'hAA, 1'b1, "emptyRW");
    applyStimulus(1'b0, 8'h00, 1'b1, "emptyRWRead");
    checkOutput("emptyRWData", 32'(dataOut), 32'hAA);

    // Simultaneous read/write on a full queue
    for (int i = 1; i <= Depth; i++) applyStimulus(1'b1, 8'(i), 1'b0, "refill");
    applyStimulus(1'b1, 8'h55, 1'b1, "fullRW");
    checkOutput("fullRWData", 32'(dataOut), 32'h01);
    for (int i = 0; i < Depth; i++) applyStimulus(1'b0, 8'h00, 1'b1, "fullRWDrain");
    checkOutput("fullRWLast", 32'(dataOut), 32'h55);

    // Asynchronous reset with 7 words queued
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 8'(8'h70 + i), 1'b0, "preReset");
    writeEn = 1'b0; readEn = 1'b0;
    rst_n = 1'b0;
    #2;
    model.delete();
    expOut = 8'h00; expValid = 1'b0; expOverflow = 1'b0; expUnderflow = 1'b0;
    compareAll("asyncReset");
    #2;
    rst_n = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b1, "postResetRead");

    // Randomized traffic with a drifting write bias to visit full and empty
    for (int i = 0; i < 3000; i++) begin
      int wBias;
      wBias = ((i / 200) % 2 == 0) ? 70 : 30;
      applyStimulus($urandom_range(0, 99) < wBias, 8'($urandom),
                    $urandom_range(0, 99) < (100 - wBias), "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_queue_fifo

// File: doc/queue_fifo.md
QUEUE_FIFO -- requirements
Module: queue_fifo

Interface
REQ-001 Parameter DataWidth, 8: width of each stored word.
REQ-002 Parameter AddrBits, 4: address width; depth = 2**AddrBits (16 by default).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 WriteEn  input  1  write request for DataIn in this cycle.
REQ-006 DataIn  input  DataWidth  write data.
REQ-007 ReadEn  input  1  read request in this cycle.
REQ-008 DataOut  output  DataWidth  registered read data.
REQ-009 DataValid  output  1  DataOut holds a word popped on the previous edge; high for exactly one cycle per pop.
REQ-010 Full  output  1  queue holds depth words.
REQ-011 Empty  output  1  queue holds 0 words.
REQ-012 Count  output  AddrBits+1  number of stored words, 0..depth.
REQ-013 Overflow  output  1  one-cycle pulse: write rejected because the queue was full.
REQ-014 Underflow  output  1  one-cycle pulse: read rejected because the queue was empty.

Function
REQ-015 Write and read pointers SHALL each be AddrBits+1 bits wide: the low AddrBits bits address storage and the MSB is a wrap bit.
REQ-016 Each pointer SHALL increment by 1 modulo 2**(AddrBits+1) on an accepted operation, so the address wraps from depth-1 to 0 and toggles the wrap bit.
REQ-017 Empty SHALL be 1 exactly when all AddrBits+1 bits of the two pointers are equal.
REQ-018 Full SHALL be 1 exactly when the address bits are equal and the wrap bits differ.
REQ-019 Empty and Full SHALL be combinational decodes of the registered pointers, with no added latency.
REQ-020 Count SHALL equal WritePtr minus ReadPtr, modulo 2**(AddrBits+1).
REQ-021 A write SHALL be accepted when WriteEn=1 and either (Full=0) or (Full=1 and ReadEn=1).
REQ-022 On an accepted write, DataIn SHALL be stored at WritePtr's address on the edge.
REQ-023 A read SHALL be accepted when ReadEn=1 and Empty=0.
REQ-024 On an accepted read, DataOut SHALL take mem[ReadPtr address] on the same edge and DataValid SHALL be 1 for the next cycle; read latency is 1 cycle.
REQ-025 When no read is accepted, DataOut SHALL hold its last value and DataValid SHALL be 0.
REQ-026 Simultaneous read and write when Empty=1: the write is accepted, the read is rejected with Underflow=1, and data is never bypassed.
REQ-027 Simultaneous read and write when Full=1: both are accepted, Count is unchanged and Full stays 1.
REQ-028 Simultaneous read and write when 0<Count<depth: both are accepted and Count is unchanged.
REQ-029 Overflow SHALL pulse for one cycle when WriteEn=1, Full=1 and ReadEn=0; the pointer and storage are unchanged.
REQ-030 Underflow SHALL pulse for one cycle when ReadEn=1 and Empty=1; the pointer is unchanged.

Reset
REQ-031 While rst_n=0 the block SHALL set WritePtr=0, ReadPtr=0, DataOut=0, DataValid=0, Overflow=0 and Underflow=0, giving Empty=1, Full=0 and Count=0.
REQ-032 Storage contents SHALL NOT be reset.
REQ-033 Reset asserted mid-operation SHALL discard all queued words immediately, without waiting for a clock edge.
REQ-034 The first operation after release SHALL be taken at the first rising clk edge with rst_n=1.

Structure
REQ-035 A shared package SHALL hold the default DataWidth and AddrBits constants and the pointer-width constant AddrBits+1.
REQ-036 The pointer equality check SHALL be one sub-module, ptr_compare, instantiated twice: once on the full pointers (Empty) and once on the address bits (Full address match).
REQ-037 Storage SHALL be a register array inside queue_fifo, with no separate memory module.

Verification
REQ-038 After reset, write 16 words 0x01..0x10 -> Full=1 after the 16th edge, Count=16, Empty=0.
REQ-039 Queue full, WriteEn=1, ReadEn=0 -> Overflow pulses for 1 cycle, Count stays 16, then 16 reads return 0x01..0x10 in order with DataValid high one cycle after each read.
REQ-040 Write 10, read 10, write 10, read 10 (pointer wrap) -> data returned in order, Empty=1 and Count=0 at the end.
REQ-041 Empty queue, ReadEn=1 and WriteEn=1 with DataIn=0xAA -> Underflow=1, DataValid=0, Count=1; the next read returns 0xAA.
REQ-042 Full queue, ReadEn=1 and WriteEn=1 with DataIn=0x55 -> DataOut=0x01 on the next cycle, Full stays 1; 0x55 is the 16th word read out.
REQ-043 rst_n pulsed low mid-cycle with Count=7 -> Empty=1 and Count=0 immediately; a subsequent read raises Underflow.
